// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave giving the PowerPC a bank of 32-bit control registers for the fabric,
// with byte enables, read-back, per-register write strobes and self-clearing pulse mode.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [63:0] C_PULSE_MASK = 64'd0,
  parameter int          C_PULSE_LEN  = 1,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:3]                  OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]    user_data_out,
  output logic [C_NUM_REGS-1:0]       user_strobe
);

  localparam int                      IW         = C_OPB_AWIDTH - 2;
  localparam logic [C_OPB_AWIDTH-1:0] BASE       = C_OPB_AWIDTH'(C_BASEADDR);
  localparam logic [C_OPB_AWIDTH-1:0] HIGH       = C_OPB_AWIDTH'(C_HIGHADDR);
  localparam logic [15:0]             PULSE_LEN  = 16'(C_PULSE_LEN);
  localparam logic                    FAMILY_SET = (C_FAMILY != "");

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                            state_q;
  logic                              hit_q;
  logic                              rnw_q;
  logic [3:0]                        be_q;
  logic [31:0]                       wdata_q;
  logic [IW-1:0]                     idx_q;
  logic                              ack_q;
  logic [31:0]                       rdata_q;
  logic [C_NUM_REGS-1:0][31:0]       regs_q, regs_d;
  logic [C_NUM_REGS-1:0][15:0]       cnt_q, cnt_d;
  logic [C_NUM_REGS-1:0]             strobe_q, strobe_d;

  logic [C_OPB_AWIDTH-1:0]           addr_s;
  logic [C_OPB_AWIDTH-1:0]           offset_s;
  logic                              hit_s;
  logic                              wr_s;
  logic [31:0]                       rd_s;
  logic                              unused_ok;

  assign addr_s    = OPB_ABus;
  assign offset_s  = addr_s - BASE;
  assign hit_s     = OPB_select && (addr_s >= BASE) && (addr_s <= HIGH);
  assign wr_s      = (state_q == S_ACK) && !rnw_q;
  assign unused_ok = ^{OPB_seqAddr, FAMILY_SET, offset_s[1:0]};

  // Read mux; indices past the bank fall through to zero.
  always_comb begin
    rd_s = 32'd0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      rd_s = (idx_q == IW'(k)) ? regs_q[k] : rd_s;
    end
  end

  // Register bank next state: byte-enabled commit, strobe, pulse countdown.
  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    strobe_d = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (wr_s && (idx_q == IW'(k))) begin
        strobe_d[k] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          regs_d[k][8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : regs_q[k][8*b +: 8];
        end
        cnt_d[k] = C_PULSE_MASK[k] ? PULSE_LEN : 16'd0;
      end else if (C_PULSE_MASK[k] && (cnt_q[k] == 16'd1)) begin
        regs_d[k] = 32'd0;
        cnt_d[k]  = 16'd0;
      end else if (cnt_q[k] != 16'd0) begin
        cnt_d[k] = cnt_q[k] - 16'd1;
      end else begin
        regs_d[k] = regs_q[k];
      end
    end
  end

  // Register bank flops; reset wins over a coincident commit.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      regs_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= '0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Transfer FSM: one ack per select assertion, request captured while idle.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= S_IDLE;
      hit_q   <= 1'b0;
      rnw_q   <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      hit_q <= hit_s && (state_q == S_IDLE);
      if ((state_q == S_IDLE) && !hit_q) begin
        rnw_q   <= OPB_RNW;
        be_q    <= OPB_BE;
        wdata_q <= OPB_DBus;
        idx_q   <= offset_s[C_OPB_AWIDTH-1:2];
      end
      case (state_q)
        S_IDLE: begin
          if (hit_q) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            rdata_q <= rnw_q ? rd_s : 32'd0;
          end else begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
          end
        end
        S_ACK: begin
          state_q <= S_WAIT;
          ack_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        S_WAIT: begin
          if (!OPB_select) begin
            state_q <= S_IDLE;
          end
          ack_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
      endcase
    end
  end

  assign Sl_xferAck    = ack_q;
  assign Sl_DBus       = rdata_q;
  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;
  assign user_data_out = regs_q;
  assign user_strobe   = strobe_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: directed vector table, randomized traffic against
// a word-array model, and hand sequences for hold-select, pulse mode and reset abort.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] HIGH = 32'h4000_00FF;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         rnw;
  logic         seq;
  logic [0:31]  abus;
  logic [0:31]  dbus;
  logic [0:3]   be;

  logic [0:31]  sl_dbus, l_dbus;
  logic         ack, err, retry, tout;
  logic         l_ack, l_err, l_retry, l_tout;
  logic [127:0] udo, l_udo;
  logic [3:0]   stb, l_stb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_REGS(4), .C_PULSE_MASK(64'h8), .C_PULSE_LEN(3), .C_FAMILY("virtex5")
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry), .Sl_toutSup(tout),
    .user_data_out(udo), .user_strobe(stb)
  );

  // Second bank on the same bus with a longer pulse so a rewrite lands mid-pulse.
  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_REGS(4), .C_PULSE_MASK(64'h8), .C_PULSE_LEN(6), .C_FAMILY("virtex5")
  ) dut_l (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(l_dbus),
    .Sl_xferAck(l_ack), .Sl_errAck(l_err), .Sl_retry(l_retry), .Sl_toutSup(l_tout),
    .user_data_out(l_udo), .user_strobe(l_stb)
  );

  int   stb_cnt  = 0;
  int   nz3_cnt  = 0;
  int   run3_cnt = 0;
  int   nzl_cnt  = 0;
  int   runl_cnt = 0;
  int   tie_bad  = 0;
  logic prev3    = 1'b0;
  logic prevl    = 1'b0;

  // Running tallies of strobe cycles, pulse-register high cycles/runs and tie-off violations.
  always @(negedge clk) begin
    stb_cnt = stb_cnt + $countones(stb);
    if (|udo[127:96]) nz3_cnt = nz3_cnt + 1;
    if ((|udo[127:96]) && !prev3) run3_cnt = run3_cnt + 1;
    prev3 = |udo[127:96];
    if (|l_udo[127:96]) nzl_cnt = nzl_cnt + 1;
    if ((|l_udo[127:96]) && !prevl) runl_cnt = runl_cnt + 1;
    prevl = |l_udo[127:96];
    if (err || retry || tout || l_err || l_retry || l_tout) tie_bad = tie_bad + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One OPB transfer; select held for 'hold' edges after the hit edge, then released.
  task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                      input logic [31:0] d, input int hold,
                      output int acks, output int pos, output logic [31:0] rd,
                      output int dz_bad);
    acks = 0; pos = -1; rd = 32'd0; dz_bad = 0;
    @(posedge clk); #1;
    abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
    for (int c = 0; c <= hold + 1; c++) begin
      @(posedge clk); #1;
      if (c == hold) sel = 1'b0;
      @(negedge clk);
      if (ack) begin
        acks++;
        if (acks == 1) begin
          pos = c;
          rd  = sl_dbus;
        end
      end else if (sl_dbus !== 32'd0) begin
        dz_bad++;
      end
    end
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          exp_acks;
    logic [31:0] exp_rd;
    logic [31:0] exp_u2;
    int          exp_stb;
  } vec_t;

  vec_t        vecs [0:13];
  logic [31:0] model [0:63];

  initial begin
    int          acks, pos, dzb, s0, n3, r3, nl, rl;
    logic [31:0] rd, a, d, mask, exp_rd;
    logic [3:0]  b;
    logic        r, in_win;
    int unsigned idx, kind;

    vecs[0]  = '{BASE + 32'h00, 1'b1, 4'hF, 32'h0,        1, 32'h0,        32'h0,        0};
    vecs[1]  = '{BASE + 32'h04, 1'b1, 4'hF, 32'h0,        1, 32'h0,        32'h0,        0};
    vecs[2]  = '{BASE + 32'h08, 1'b1, 4'hF, 32'h0,        1, 32'h0,        32'h0,        0};
    vecs[3]  = '{BASE + 32'h0C, 1'b1, 4'hF, 32'h0,        1, 32'h0,        32'h0,        0};
    vecs[4]  = '{BASE + 32'h08, 1'b0, 4'hF, 32'hDEADBEEF, 1, 32'h0,        32'hDEADBEEF, 1};
    vecs[5]  = '{BASE + 32'h08, 1'b0, 4'h1, 32'h000000AA, 1, 32'h0,        32'hDEADBEAA, 1};
    vecs[6]  = '{BASE + 32'h08, 1'b1, 4'hF, 32'h0,        1, 32'hDEADBEAA, 32'hDEADBEAA, 0};
    vecs[7]  = '{BASE + 32'h08, 1'b0, 4'h0, 32'h11223344, 1, 32'h0,        32'hDEADBEAA, 1};
    vecs[8]  = '{BASE + 32'h08, 1'b0, 4'hC, 32'h55660000, 1, 32'h0,        32'h5566BEAA, 1};
    vecs[9]  = '{BASE + 32'h100, 1'b1, 4'hF, 32'h0,       0, 32'h0,        32'h5566BEAA, 0};
    vecs[10] = '{BASE + 32'h14, 1'b0, 4'hF, 32'h00000012, 1, 32'h0,        32'h5566BEAA, 0};
    vecs[11] = '{BASE + 32'h14, 1'b1, 4'hF, 32'h0,        1, 32'h0,        32'h5566BEAA, 0};
    vecs[12] = '{BASE - 32'h04, 1'b1, 4'hF, 32'h0,        0, 32'h0,        32'h5566BEAA, 0};
    vecs[13] = '{BASE + 32'h08, 1'b1, 4'hF, 32'h0,        1, 32'h5566BEAA, 32'h5566BEAA, 0};

    rst = 1'b1; sel = 1'b0; rnw = 1'b1; seq = 1'b0;
    abus = 32'd0; dbus = 32'd0; be = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ack",    32'(ack),   32'd0);
    check("reset_dbus",   sl_dbus,    32'd0);
    check("reset_udo",    udo,        128'd0);
    check("reset_strobe", 32'(stb),   32'd0);
    check("reset_udo_l",  l_udo,      128'd0);

    for (int i = 0; i < 14; i++) begin
      s0 = stb_cnt;
      xfer(vecs[i].addr, vecs[i].rnw, vecs[i].be, vecs[i].wdata, 2, acks, pos, rd, dzb);
      check($sformatf("vec%0d_acks", i), 32'(acks), 32'(vecs[i].exp_acks));
      if (vecs[i].exp_acks == 1) check($sformatf("vec%0d_latency", i), 32'(pos), 32'd1);
      if (vecs[i].rnw && vecs[i].exp_acks == 1) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_dbus_idle", i), 32'(dzb), 32'd0);
      check($sformatf("vec%0d_reg2", i), udo[95:64], vecs[i].exp_u2);
      check($sformatf("vec%0d_strobes", i), 32'(stb_cnt - s0), 32'(vecs[i].exp_stb));
    end

    xfer(BASE + 32'h08, 1'b1, 4'hF, 32'h0, 10, acks, pos, rd, dzb);
    check("hold_select_acks",  32'(acks), 32'd1);
    check("hold_select_rdata", rd,        32'h5566BEAA);

    for (int i = 0; i < 64; i++) model[i] = 32'd0;
    model[2] = 32'h5566BEAA;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      idx  = 0;
      in_win = 1'b1;
      if (kind < 6) begin
        idx = $urandom_range(0, 2);
        a   = BASE + 32'(4 * idx);
      end else if (kind < 8) begin
        idx = $urandom_range(4, 63);
        a   = BASE + 32'(4 * idx);
      end else begin
        in_win = 1'b0;
        a = ($urandom_range(0, 1) == 1) ? HIGH + 32'd1 + 32'(4 * $urandom_range(0, 15))
                                        : BASE - 32'd4 - 32'(4 * $urandom_range(0, 15));
      end
      r = 1'($urandom_range(0, 1));
      b = 4'($urandom_range(0, 15));
      d = $urandom();
      exp_rd = (idx < 4) ? model[idx] : 32'd0;
      s0 = stb_cnt;
      xfer(a, r, b, d, 2, acks, pos, rd, dzb);
      check($sformatf("rand%0d_acks", it), 32'(acks), in_win ? 32'd1 : 32'd0);
      if (r && in_win) check($sformatf("rand%0d_rdata", it), rd, exp_rd);
      if (!r && in_win && idx < 4) begin
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        model[idx] = (model[idx] & ~mask) | (d & mask);
      end
      check($sformatf("rand%0d_strobes", it), 32'(stb_cnt - s0),
            (!r && in_win && idx < 4) ? 32'd1 : 32'd0);
      check($sformatf("rand%0d_regs", it), {32'd0, udo[95:0]},
            {32'd0, model[2], model[1], model[0]});
    end

    n3 = nz3_cnt; r3 = run3_cnt; nl = nzl_cnt; rl = runl_cnt;
    xfer(BASE + 32'h0C, 1'b0, 4'hF, 32'h1, 2, acks, pos, rd, dzb);
    check("pulse_acks", 32'(acks), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    check("pulse3_cycles", 32'(nz3_cnt - n3),  32'd3);
    check("pulse3_runs",   32'(run3_cnt - r3), 32'd1);
    check("pulse6_cycles", 32'(nzl_cnt - nl),  32'd6);
    check("pulse6_runs",   32'(runl_cnt - rl), 32'd1);

    n3 = nz3_cnt; r3 = run3_cnt; nl = nzl_cnt; rl = runl_cnt;
    xfer(BASE + 32'h0C, 1'b0, 4'hF, 32'h1, 2, acks, pos, rd, dzb);
    xfer(BASE + 32'h0C, 1'b0, 4'hF, 32'h2, 2, acks, pos, rd, dzb);
    check("rewrite_value3", udo[127:96],   32'h2);
    check("rewrite_value6", l_udo[127:96], 32'h2);
    repeat (15) @(negedge clk);
    #1;
    check("rewrite3_cycles", 32'(nz3_cnt - n3),  32'd6);
    check("rewrite3_runs",   32'(run3_cnt - r3), 32'd2);
    check("rewrite6_cycles", 32'(nzl_cnt - nl),  32'd11);
    check("rewrite6_runs",   32'(runl_cnt - rl), 32'd1);
    check("pulse_cleared",   l_udo[127:96],      32'h0);

    @(posedge clk); #1;
    abus = BASE; rnw = 1'b0; be = 4'hF; dbus = 32'h12345678; sel = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; sel = 1'b0;
    @(negedge clk);
    check("abort_ack_seen", 32'(ack), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ack_drop", 32'(ack),  32'd0);
    check("abort_reg0",     udo[31:0], 32'd0);
    check("abort_strobe",   32'(stb),  32'd0);
    check("abort_reg2",     udo[95:64], 32'd0);
    xfer(BASE, 1'b1, 4'hF, 32'h0, 2, acks, pos, rd, dzb);
    check("post_abort_acks",  32'(acks), 32'd1);
    check("post_abort_rdata", rd,        32'd0);
    xfer(BASE, 1'b0, 4'hF, 32'hCAFEF00D, 2, acks, pos, rd, dzb);
    xfer(BASE, 1'b1, 4'hF, 32'h0, 2, acks, pos, rd, dzb);
    check("post_abort_readback", rd, 32'hCAFEF00D);

    check("tie_offs_zero", 32'(tie_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
